// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared pipeline-control types, defaults and the register-dependence helper.
package cpu_ctrl_pkg;
  typedef enum logic {RUN, MD_WAIT} state_t;
  localparam int MD_LATENCY_DEF = 4;
  localparam logic [4:0] REG_ZERO = 5'd0;
  function automatic logic reg_match(
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic use_rs,
    input logic use_rt,
    input logic [4:0] x
  );
    return (x != REG_ZERO) && ((use_rs && rs == x) || (use_rt && rt == x));
  endfunction
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: RAW stall term from ID-vs-EX/MEM register compares; HAZARD_FORWARD_EN limits it to load-use.
module hazard_detect
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic [4:0] ex_rd,
  input  logic       ex_regwrite,
  input  logic       ex_memread,
  input  logic [4:0] mem_rd,
  input  logic       mem_regwrite,
  output logic       raw_stall
);
  logic ex_hit;
  assign ex_hit = ex_regwrite && reg_match(id_rs, id_rt, id_use_rs, id_use_rt, ex_rd);
`ifdef HAZARD_FORWARD_EN
  logic unused_mem;
  assign unused_mem = ^{mem_rd, mem_regwrite};
  assign raw_stall = ex_memread && ex_hit;
`else
  // WB conflicts are covered by the first-half-cycle register-file write.
  logic unused_load;
  assign unused_load = ex_memread;
  assign raw_stall = ex_hit || (mem_regwrite && reg_match(id_rs, id_rt, id_use_rs, id_use_rt, mem_rd));
`endif
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: PC/IF/ID/ID/EX/EX/MEM advance-hold-flush sequencing for the five-stage core (option: HAZARD_FORWARD_EN).
module hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEF,
  localparam int CNT_W = $clog2(MD_LATENCY) + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       id_jump,
  input  logic [4:0] ex_rd,
  input  logic       ex_regwrite,
  input  logic       ex_memread,
  input  logic       ex_md_start,
  input  logic       ex_branch_taken,
  input  logic [4:0] mem_rd,
  input  logic       mem_regwrite,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       idex_write,
  output logic       idex_bubble,
  output logic       exmem_bubble,
  output logic       md_busy
);
  localparam logic MD_MULTI = MD_LATENCY > 1;
  state_t state;
  logic [CNT_W-1:0] md_cnt;
  logic raw_stall, md_hold, advance;
  hazard_detect u_detect (
    .id_rs(id_rs),
    .id_rt(id_rt),
    .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt),
    .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread),
    .mem_rd(mem_rd),
    .mem_regwrite(mem_regwrite),
    .raw_stall(raw_stall)
  );
  assign md_hold = (state == RUN && ex_md_start && MD_MULTI) || (state == MD_WAIT && md_cnt != '0);
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      md_cnt  <= '0;
      md_busy <= 1'b0;
    end else if (state == RUN) begin
      if (ex_md_start && MD_MULTI) begin
        state   <= MD_WAIT;
        md_cnt  <= CNT_W'(MD_LATENCY - 2);
        md_busy <= 1'b1;
      end
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - CNT_W'(1);
    end else begin
      state   <= RUN;
      md_busy <= 1'b0;
    end
  end
  // A taken branch overrides a RAW stall; a jump only acts when no stall.
  assign advance      = !rst && !md_hold && (ex_branch_taken || !raw_stall);
  assign pc_write     = advance;
  assign ifid_write   = advance;
  assign ifid_flush   = rst || (!md_hold && (ex_branch_taken || (!raw_stall && id_jump)));
  assign idex_write   = rst || !md_hold;
  assign idex_bubble  = rst || (!md_hold && (ex_branch_taken || raw_stall));
  assign exmem_bubble = !rst && md_hold;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of hazard_ctrl outputs {pc_write,ifid_write,ifid_flush,idex_write,idex_bubble,exmem_bubble,md_busy}.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic id_use_rs, id_use_rt, id_jump, ex_regwrite, ex_memread, ex_md_start, ex_branch_taken, mem_regwrite;
  logic pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble, md_busy;
  int passed = 0;
  int total = 0;
  localparam logic [6:0] DEF   = 7'b1101000;
  localparam logic [6:0] RST   = 7'b0011100;
  localparam logic [6:0] STALL = 7'b0001100;
  localparam logic [6:0] MDH   = 7'b0000010;
  localparam logic [6:0] MDW   = 7'b0000011;
  localparam logic [6:0] BR    = 7'b1111100;
  localparam logic [6:0] JMP   = 7'b1111000;
`ifdef HAZARD_FORWARD_EN
  localparam logic [6:0] MEMHZ = DEF;
`else
  localparam logic [6:0] MEMHZ = STALL;
`endif
  always #5 clk = ~clk;
  hazard_ctrl #(.MD_LATENCY(4)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_jump(id_jump), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_md_start(ex_md_start), .ex_branch_taken(ex_branch_taken), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_write(idex_write),
    .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble), .md_busy(md_busy)
  );
  task automatic step(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    @(negedge clk);
    obs = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble, md_busy};
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    {id_rs, id_rt, ex_rd, mem_rd} = '0;
    {id_use_rs, id_use_rt, id_jump, ex_regwrite, ex_memread, ex_md_start, ex_branch_taken, mem_regwrite} = '0;
  endtask
  initial begin
    idle();
    rst = 1'b1;
    ex_md_start = 1'b1;
    #1;
    step("reset_c1", RST);
    step("reset_c2", RST);
    rst = 1'b0;
    ex_md_start = 1'b0;
    step("after_reset", DEF);
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
    step("load_use", STALL);
    idle();
    step("load_use_clear", DEF);
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
    step("load_r0", DEF);
    idle();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_use_rs = 1'b0;
    step("rs_not_used", DEF);
    idle();
    mem_regwrite = 1'b1; mem_rd = 5'd5; id_rt = 5'd5; id_use_rt = 1'b1;
    step("mem_dep", MEMHZ);
    idle();
    ex_branch_taken = 1'b1;
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd9; id_rt = 5'd9; id_use_rt = 1'b1;
    step("branch_over_stall", BR);
    ex_branch_taken = 1'b0; id_jump = 1'b1;
    step("jump_in_stall", STALL);
    idle();
    id_jump = 1'b1;
    step("jump", JMP);
    idle();
    ex_md_start = 1'b1;
    step("md_c1", MDH);
    ex_branch_taken = 1'b1;
    step("md_c2_branch", MDW);
    ex_branch_taken = 1'b0;
    step("md_c3", MDW);
    step("md_c4_advance", 7'b1101001);
    ex_md_start = 1'b0;
    step("md_done", DEF);
    ex_md_start = 1'b1;
    step("mdr_c1", MDH);
    ex_md_start = 1'b0;
    step("mdr_c2", MDW);
    rst = 1'b1;
    step("mdr_reset", 7'b0011101);
    rst = 1'b0;
    step("mdr_after", DEF);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage MIPS core. It decides each cycle whether the PC and the IF/ID, ID/EX and EX/MEM pipeline registers advance, hold, flush or take a bubble. Inputs are:
- register dependences between ID and the later stages,
- branch resolution in EX,
- jumps resolved in ID,
- a multi-cycle multiply/divide occupying EX.

It sits beside the stage registers in the core top and drives their write-enable and flush inputs.

## Interface
Parameters:
- MD_LATENCY, 4: total cycles a mul/div instruction occupies EX, counting its first cycle; legal range 1..16.
- CNT_W, $clog2(MD_LATENCY)+1: width of the mul/div counter; derived, never overridden.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_jump  in  1  jump or jr resolved in ID this cycle.
- ex_rd  in  5  destination register of the instruction in EX (after the RegDst mux).
- ex_regwrite  in  1  EX instruction writes the register file.
- ex_memread  in  1  EX instruction is a load.
- ex_md_start  in  1  EX holds a mul/div instruction.
- ex_branch_taken  in  1  branch in EX resolved taken.
- mem_rd  in  5  destination register of the instruction in MEM.
- mem_regwrite  in  1  MEM instruction writes the register file.
- pc_write  out  1  PC loads its next value.
- ifid_write  out  1  IF/ID loads.
- ifid_flush  out  1  IF/ID loads a NOP; takes precedence over ifid_write.
- idex_write  out  1  ID/EX loads.
- idex_bubble  out  1  ID/EX loads all-zero controls.
- exmem_bubble  out  1  EX/MEM loads all-zero controls.
- md_busy  out  1  registered; high while in MD_WAIT.

## Operation
State machine with two states:
- RUN: normal issue.
- MD_WAIT: mul/div in progress. Counter md_cnt (CNT_W bits) is held.

Transitions:
- RUN with ex_md_start=1 and MD_LATENCY>1: go to MD_WAIT and load md_cnt=MD_LATENCY-2.
- MD_WAIT with md_cnt≠0: stay in MD_WAIT and decrement md_cnt.
- MD_WAIT with md_cnt=0: go to RUN.
- In MD_WAIT, ex_md_start is ignored.

Hazard terms:
- Hazard match: (id_use_rs and id_rs==X) or (id_use_rt and id_rt==X), with X≠0. Register 0 never matches.
- load_use: ex_memread, ex_regwrite, and a match on ex_rd.

Output priority, highest first. Any output not named in a case takes its default (pc_write=1, ifid_write=1, idex_write=1, all others 0).
1. rst: pc_write=0, ifid_write=0, ifid_flush=1, idex_write=1, idex_bubble=1, exmem_bubble=0.
2. md_hold, i.e. (RUN and ex_md_start and MD_LATENCY>1) or (MD_WAIT and md_cnt≠0): pc_write=0, ifid_write=0, idex_write=0, exmem_bubble=1.
3. ex_branch_taken: pc_write=1, ifid_flush=1, idex_bubble=1.
4. RAW stall: pc_write=0, ifid_write=0, idex_bubble=1.
5. id_jump: pc_write=1, ifid_flush=1.
6. Otherwise: the defaults.

Further rules:
- A jump that arrives during a RAW stall is ignored. It is re-presented the next cycle, because IF/ID holds.
- rst asserted in MD_WAIT returns the block to RUN with md_cnt=0 on the next edge.

## Timing
- All outputs are combinational from state, md_cnt and the inputs. md_busy is the only registered output.
- Reset state: RUN, md_cnt=0, md_busy=0.
- A RAW stall lasts exactly as long as the hazard persists. With forwarding that is one cycle for load-use.
- A mul/div freezes the front end for MD_LATENCY-1 cycles, counting its start cycle. On the MD_LATENCY-th cycle the pipeline advances.
- With MD_LATENCY=1 the block never enters MD_WAIT.
- A taken branch costs two squashed instructions: IF/ID and ID/EX on the same edge.

## Configuration
- Macro HAZARD_FORWARD_EN.
- Defined: RAW stall = load_use only. The datapath forwards from EX/MEM and MEM/WB.
- Undefined: RAW stall = match on ex_rd (when ex_regwrite) or match on mem_rd (when mem_regwrite). A WB-stage conflict needs no stall, because the register file writes in the first half-cycle.

## Structure
- Shared package cpu_ctrl_pkg holds:
  - the state enum (RUN, MD_WAIT);
  - the MD_LATENCY default constant;
  - the register-zero constant.
- One combinational sub-module, hazard_detect: register compares producing the RAW stall term. The HAZARD_FORWARD_EN selection lives inside it.
- The FSM, counter and output priority stay in hazard_ctrl.

## Test plan
- Reset: rst=1 for 2 cycles with ex_md_start=1 → pc_write=0, ifid_flush=1, idex_bubble=1, md_busy=0. After release, state is RUN.
- Load-use (forwarding on): ex_memread=1, ex_regwrite=1, ex_rd=8, id_rs=8, id_use_rs=1 → one cycle of pc_write=0, ifid_write=0, idex_bubble=1. Repeat with ex_rd=0 → no stall.
- Forwarding off: mem_regwrite=1, mem_rd=5, id_rt=5, id_use_rt=1 → stall. Same stimulus with HAZARD_FORWARD_EN defined → no stall.
- Mul/div with MD_LATENCY=4: ex_md_start pulse held for 4 cycles → pc_write low for exactly 3 cycles and high on the 4th. md_busy is high for the 3 cycles after the start edge.
- Branch vs. stall: ex_branch_taken=1 with a simultaneous load-use → pc_write=1, ifid_flush=1, idex_bubble=1. id_jump together with a load-use → stall only, ifid_flush=0.
- Reset mid mul/div: rst asserted in the 2nd MD_WAIT cycle → next cycle RUN, md_busy=0, no residual hold.
